// File: rtl/ddf_token_dispatcher_if.sv
// Upstream token stream plus the nda / data FIFO write side of the DDF token dispatcher.
// slave is the dispatcher's view, master is the environment's view.
interface ddf_token_dispatcher_if #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2,
  parameter int PORTS = 2,
  parameter int SEL_W = 1
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      in_sel;
  logic [WIDTH-1:0]      in_data;
  logic                  nda_write;
  logic [WIDTH-1:0]      nda_dataout;
  logic [FLUX-1:0]       nda_full;
  logic [PORTS-1:0]      out_write;
  logic [WIDTH-1:0]      out_dataout;
  logic [PORTS*FLUX-1:0] out_full;
  logic                  err_sel;
  logic [15:0]           tok_count;

  modport slave (
    input  in_valid, in_sel, in_data, nda_full, out_full,
    output in_ready, nda_write, nda_dataout, out_write, out_dataout, err_sel, tok_count
  );

  modport master (
    output in_valid, in_sel, in_data, nda_full, out_full,
    input  in_ready, nda_write, nda_dataout, out_write, out_dataout, err_sel, tok_count
  );
endinterface

// File: rtl/ddf_token_dispatcher.sv
// Splits tagged tokens into an nda control write and a data write; strobes follow acceptance by one cycle.
// Each half waits independently on its own full flag; in_ready stays low until both halves are written.
module ddf_token_dispatcher #(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2,
  parameter int PORTS = 2,
  parameter int SEL_W = 1
) (
  input  logic clk,
  input  logic rst,
  ddf_token_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_NDA  = 2'd2,
    WAIT_DATA = 2'd3
  } state_t;

  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic [15:0]      cnt_q;

  logic             nda_ok;
  logic             dat_ok;
  logic             sel_bad;
  logic             nda_wr;
  logic             dat_wr;
  logic             done;
  logic [PORTS-1:0] sel_oh;

  assign nda_ok  = ~|bus.nda_full;
  assign sel_bad = int'(bus.in_sel) >= PORTS;
  assign sel_oh  = PORTS'(1) << sel_q;

  // Any set bit in the selected FIFO's flag slice stalls the data write.
  always_comb begin
    dat_ok = 1'b1;
    for (int i = 0; i < PORTS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        dat_ok = ~|bus.out_full[i*FLUX +: FLUX];
      end
    end
  end

  always_comb begin
    nda_wr = 1'b0;
    dat_wr = 1'b0;
    done   = 1'b0;
    case (state_q)
      SEND: begin
        nda_wr = nda_ok;
        dat_wr = dat_ok;
        done   = nda_ok && dat_ok;
      end
      WAIT_NDA: begin
        nda_wr = nda_ok;
        done   = nda_ok;
      end
      WAIT_DATA: begin
        dat_wr = dat_ok;
        done   = dat_ok;
      end
      default: begin
        nda_wr = 1'b0;
        dat_wr = 1'b0;
        done   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (sel_bad) begin
              err_q <= 1'b1;
            end else begin
              sel_q   <= bus.in_sel;
              data_q  <= bus.in_data;
              state_q <= SEND;
            end
          end
        end
        SEND: begin
          if (nda_ok && dat_ok) begin
            state_q <= IDLE;
          end else if (nda_ok) begin
            state_q <= WAIT_DATA;
          end else if (dat_ok) begin
            state_q <= WAIT_NDA;
          end
        end
        WAIT_NDA: begin
          if (nda_ok) begin
            state_q <= IDLE;
          end
        end
        WAIT_DATA: begin
          if (dat_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (done) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Reset is folded in so upstream never sees ready while the block is held in reset.
  assign bus.in_ready    = (state_q == IDLE) && rst;
  assign bus.nda_write   = nda_wr;
  assign bus.nda_dataout = WIDTH'(sel_q);
  assign bus.out_write   = dat_wr ? sel_oh : '0;
  assign bus.out_dataout = data_q;
  assign bus.err_sel     = err_q;
  assign bus.tok_count   = cnt_q;

endmodule

// File: tb/tb_ddf_token_dispatcher.sv
// Directed bench for ddf_token_dispatcher; SEL_W=2 so an out-of-range selector can be driven.
module tb_ddf_token_dispatcher;
  localparam int WIDTH = 8;
  localparam int FLUX  = 2;
  localparam int PORTS = 2;
  localparam int SEL_W = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ddf_token_dispatcher_if #(.WIDTH(WIDTH), .FLUX(FLUX), .PORTS(PORTS), .SEL_W(SEL_W)) bus ();

  ddf_token_dispatcher #(.WIDTH(WIDTH), .FLUX(FLUX), .PORTS(PORTS), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0;
    bus.nda_full = '0;   bus.out_full = '0;
    #3;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", bus.in_ready); end
    total++; if (bus.nda_write !== 1'b0) begin bad++; $display("FAIL rst_nda_write got=%0h exp=0", bus.nda_write); end
    total++; if (bus.out_write !== 2'b00) begin bad++; $display("FAIL rst_out_write got=%0h exp=0", bus.out_write); end
    total++; if (bus.nda_dataout !== 8'h00 || bus.out_dataout !== 8'h00) begin bad++; $display("FAIL rst_dataout got=%0h/%0h exp=0/0", bus.nda_dataout, bus.out_dataout); end
    total++; if (bus.err_sel !== 1'b0 || bus.tok_count !== 16'd0) begin bad++; $display("FAIL rst_err_cnt got=%0h/%0d exp=0/0", bus.err_sel, bus.tok_count); end
    step(); step();
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%0h exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'hA5;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.nda_write !== 1'b1 || bus.nda_dataout !== 8'h01) begin bad++; $display("FAIL basic_nda got=%0h/%0h exp=1/01", bus.nda_write, bus.nda_dataout); end
    total++; if (bus.out_write !== 2'b10 || bus.out_dataout !== 8'hA5) begin bad++; $display("FAIL basic_dat got=%0b/%0h exp=10/a5", bus.out_write, bus.out_dataout); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_rdy_low got=%0h exp=0", bus.in_ready); end
    step();
    total++; if (bus.tok_count !== 16'd1 || bus.in_ready !== 1'b1 || bus.nda_write !== 1'b0 || bus.out_write !== 2'b00) begin
      bad++; $display("FAIL basic_done got cnt=%0d rdy=%0h nw=%0h ow=%0b exp cnt=1 rdy=1 nw=0 ow=00", bus.tok_count, bus.in_ready, bus.nda_write, bus.out_write); end
  endtask

  task automatic test_nda_stall();
    bus.nda_full = 2'b01;
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h3C;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_write !== 2'b01 || bus.nda_write !== 1'b0 || bus.out_dataout !== 8'h3C) begin
      bad++; $display("FAIL ndast_send got ow=%0b nw=%0h od=%0h exp ow=01 nw=0 od=3c", bus.out_write, bus.nda_write, bus.out_dataout); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.out_write !== 2'b00 || bus.nda_write !== 1'b0 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL ndast_wait%0d got ow=%0b nw=%0h rdy=%0h exp ow=00 nw=0 rdy=0", i, bus.out_write, bus.nda_write, bus.in_ready); end
    end
    bus.nda_full = 2'b00;
    #1;
    total++; if (bus.nda_write !== 1'b1 || bus.nda_dataout !== 8'h00 || bus.out_write !== 2'b00) begin
      bad++; $display("FAIL ndast_release got nw=%0h nd=%0h ow=%0b exp nw=1 nd=00 ow=00", bus.nda_write, bus.nda_dataout, bus.out_write); end
    step();
    total++; if (bus.nda_write !== 1'b0 || bus.in_ready !== 1'b1 || bus.tok_count !== 16'd2) begin
      bad++; $display("FAIL ndast_done got nw=%0h rdy=%0h cnt=%0d exp nw=0 rdy=1 cnt=2", bus.nda_write, bus.in_ready, bus.tok_count); end
  endtask

  task automatic test_data_stall();
    bus.out_full = 4'b0010;
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h11;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.nda_write !== 1'b1 || bus.out_write !== 2'b00) begin bad++; $display("FAIL datst_send got nw=%0h ow=%0b exp nw=1 ow=00", bus.nda_write, bus.out_write); end
    step();
    total++; if (bus.nda_write !== 1'b0 || bus.out_write !== 2'b00) begin bad++; $display("FAIL datst_wait got nw=%0h ow=%0b exp nw=0 ow=00", bus.nda_write, bus.out_write); end
    step();
    bus.out_full = 4'b0000;
    #1;
    total++; if (bus.out_write !== 2'b01 || bus.out_dataout !== 8'h11 || bus.tok_count !== 16'd2) begin
      bad++; $display("FAIL datst_release got ow=%0b od=%0h cnt=%0d exp ow=01 od=11 cnt=2", bus.out_write, bus.out_dataout, bus.tok_count); end
    step();
    total++; if (bus.out_write !== 2'b00 || bus.tok_count !== 16'd3 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL datst_done got ow=%0b cnt=%0d rdy=%0h exp ow=00 cnt=3 rdy=1", bus.out_write, bus.tok_count, bus.in_ready); end
  endtask

  task automatic test_bad_sel();
    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'h55;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.nda_write !== 1'b0 || bus.out_write !== 2'b00 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL badsel_nowrite got nw=%0h ow=%0b rdy=%0h exp nw=0 ow=00 rdy=1", bus.nda_write, bus.out_write, bus.in_ready); end
    total++; if (bus.err_sel !== 1'b1 || bus.tok_count !== 16'd3) begin bad++; $display("FAIL badsel_err got err=%0h cnt=%0d exp err=1 cnt=3", bus.err_sel, bus.tok_count); end
    step();
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h77;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_write !== 2'b10 || bus.nda_dataout !== 8'h01 || bus.out_dataout !== 8'h77) begin
      bad++; $display("FAIL badsel_next got ow=%0b nd=%0h od=%0h exp ow=10 nd=01 od=77", bus.out_write, bus.nda_dataout, bus.out_dataout); end
    step();
    total++; if (bus.err_sel !== 1'b1 || bus.tok_count !== 16'd4) begin bad++; $display("FAIL badsel_sticky got err=%0h cnt=%0d exp err=1 cnt=4", bus.err_sel, bus.tok_count); end
  endtask

  task automatic test_back_to_back();
    int nda_n;
    int dat_n;
    int cyc;
    nda_n = 0; dat_n = 0; cyc = 0;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1; bus.in_sel = SEL_W'(k % 2); bus.in_data = 8'h10 + 8'(k);
      step(); cyc++;
      if (k == 7) bus.in_valid = 1'b0;
      if (bus.nda_write === 1'b1) nda_n++;
      if (bus.out_write !== 2'b00) dat_n++;
      total++; if (bus.nda_dataout !== 8'(k % 2) || bus.out_write !== ((k % 2) ? 2'b10 : 2'b01) || bus.out_dataout !== 8'h10 + 8'(k)) begin
        bad++; $display("FAIL b2b_tok%0d got nd=%0h ow=%0b od=%0h exp nd=%0h od=%0h", k, bus.nda_dataout, bus.out_write, bus.out_dataout, k % 2, 8'h10 + 8'(k)); end
      step(); cyc++;
      if (bus.nda_write === 1'b1) nda_n++;
      if (bus.out_write !== 2'b00) dat_n++;
    end
    total++; if (nda_n != 8 || dat_n != 8 || cyc != 16) begin bad++; $display("FAIL b2b_counts got nda=%0d dat=%0d cyc=%0d exp 8/8/16", nda_n, dat_n, cyc); end
    total++; if (bus.tok_count !== 16'd12) begin bad++; $display("FAIL b2b_tok_count got=%0d exp=12", bus.tok_count); end
  endtask

  task automatic test_reset_mid();
    bus.out_full = 4'b0010;
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h99;
    step();
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.in_ready !== 1'b0 || bus.nda_write !== 1'b0) begin bad++; $display("FAIL rmid_in_wait got rdy=%0h nw=%0h exp 0/0", bus.in_ready, bus.nda_write); end
    bus.out_full = 4'b0000;
    #1;
    total++; if (bus.out_write !== 2'b01) begin bad++; $display("FAIL rmid_pending got ow=%0b exp=01", bus.out_write); end
    rst = 1'b0;
    #1;
    total++; if (bus.out_write !== 2'b00 || bus.nda_write !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_strobes got ow=%0b nw=%0h rdy=%0h exp 00/0/0", bus.out_write, bus.nda_write, bus.in_ready); end
    total++; if (bus.tok_count !== 16'd0 || bus.err_sel !== 1'b0 || bus.out_dataout !== 8'h00) begin
      bad++; $display("FAIL rmid_regs got cnt=%0d err=%0h od=%0h exp 0/0/00", bus.tok_count, bus.err_sel, bus.out_dataout); end
    step();
    rst = 1'b1;
    step();
    total++; if (bus.in_ready !== 1'b1 || bus.out_write !== 2'b00 || bus.tok_count !== 16'd0) begin
      bad++; $display("FAIL rmid_after got rdy=%0h ow=%0b cnt=%0d exp 1/00/0", bus.in_ready, bus.out_write, bus.tok_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_nda_stall();
    test_data_stall();
    test_bad_sel();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
